zorro2_autoconfig_master: RTL and testbench
===========================================

Name: zorro2_autoconfig_master

Overview:
- Host-side Zorro II AutoConfig initiator: enumerates boards on the $E80000 config window, reads each board's type and size nibbles, and allocates FastRAM from the $200000-$9FFFFF pool in 1MB blocks.
- For each offer it either writes a base-address nibble (register $24) or a shut-up (register $26).
- Used in the bring-up/test fixture as the bus-master counterpart to our RAM boards, and as a stand-in for Kickstart enumeration in board-level simulation.

Parameters:
- TIMEOUT, 16: CLK cycles to wait for DTACKn before declaring "no board present".
- MAX_OFFERS, 16: maximum config cycles (allocations + shut-ups) before forced done.

Ports:
- CLK  in  1  bus clock (7 MHz domain); all state changes on posedge.
- RESETn  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins enumeration; ignored unless idle or done.
- RESERVED  in  8  1MB blocks $2..$9 already taken (bit0 = $2); latched on START.
- DTACKn  in  1  bus acknowledge, active-low.
- DBUS_IN  in  4  D[15:12] as read from bus.
- ASn, UDSn, LDSn  out  1  address/data strobes, active-low.
- RWn  out  1  1 = read.
- ADDR  out  23  A[23:1].
- DBUS_OUT  out  4  write nibble on D[15:12].
- DBUS_OE  out  1  drive DBUS_OUT onto bus.
- CFGOUTn  out  1  config chain enable to first slot, active-low.
- BUSY  out  1  enumeration in progress.
- DONE  out  1  enumeration finished; held until next START.
- FREE_MAP  out  8  allocated-block map (RESERVED OR all grants).
- OFFERS  out  5  count of config cycles completed.

Behaviour:
- Reset:
  - Strobes ASn/UDSn/LDSn/RWn = 1; ADDR = 0; DBUS_OE = 0; DBUS_OUT = 0; CFGOUTn = 1.
  - BUSY = 0, DONE = 0, FREE_MAP = 0, OFFERS = 0; FSM to IDLE.
  - Reset mid-cycle releases all strobes immediately (asynchronous).
- Bus cycle (shared by all accesses):
  - T0: ADDR, RWn, DBUS_OE/DBUS_OUT valid.
  - T1: ASn = 0, UDSn = 0; LDSn stays 1.
  - Wait until DTACKn is sampled low. Read data is sampled on the clock after DTACKn is seen low.
  - Next clock: ASn/UDSn = 1. DBUS_OE drops one clock after ASn.
  - One idle clock between cycles.
  - Timeout: TIMEOUT clocks with no DTACKn (counted from ASn low) ends the cycle with the no-ack flag set.
- States:
  - IDLE: on START, latch FREE_MAP <= RESERVED, set CFGOUTn = 0 and BUSY = 1, go to RD_TYPE.
  - RD_TYPE: read $E80000 (ADDR[8:1] = 0).
    - No-ack goes to DONE.
    - type[3:2] != 2'b11 (not Zorro II) or type[1] == 0 (not memory) goes to WR_SHUT.
    - Otherwise go to RD_SIZE.
  - RD_SIZE: read ADDR[8:1] = 1; size = DBUS_IN[2:0]. No-ack goes to DONE.
  - DECIDE:
    - Size map: 000 = 8 blocks, 111 = 4, 110 = 2, 101 = 1; other codes (sub-1MB) = unsupported, go to WR_SHUT.
    - Candidate starts: offset 0..7 with offset mod N == 0.
    - Pick the lowest candidate whose N blocks are all free and within the 8-block range.
    - If a candidate is found, go to WR_BASE; otherwise go to WR_SHUT.
  - WR_BASE: write ADDR[8:1] = 8'h24, DBUS_OUT = offset + 2 (i.e. A[23:20]). On ack, OR the granted blocks into FREE_MAP.
  - WR_SHUT: write ADDR[8:1] = 8'h26, DBUS_OUT = 0.
  - After WR_BASE or WR_SHUT:
    - OFFERS += 1.
    - If OFFERS == MAX_OFFERS go to DONE; else go to RD_TYPE.
    - A board re-offering a smaller size after shut-up, or the next board in the chain, is handled identically.
    - A write no-ack goes to DONE and FREE_MAP is not updated.
  - DONE: BUSY = 0, DONE = 1, CFGOUTn = 1; START returns to IDLE behaviour.
- ADDR[23:16] = 8'hE8 for every cycle; ADDR[15:9] = 0.
- OFFERS saturates at MAX_OFFERS.

Test Plan:
- RESERVED = 00, one board offering 8M (type E, size 0) -> write $24 data 2; FREE_MAP = FF; next RD_TYPE times out; DONE = 1, OFFERS = 1.
- RESERVED = 01, board offers 8M then 4M then 2M after shut-ups:
  - 8M gets shut-up; 4M gets base 6 (FREE_MAP = F1); total OFFERS = 2.
  - A board offering 2M first with RESERVED = 01 gets base 4.
- RESERVED = FF, board offers 1M -> shut-up at $26; board drops out; timeout; DONE, FREE_MAP = FF.
- Non-memory type (DBUS = C) -> immediate shut-up without a size read; OFFERS = 1.
- Board never acks -> ASn low for exactly TIMEOUT clocks, then released; DONE with OFFERS = 0, FREE_MAP = RESERVED.
- RESETn asserted while ASn is low during WR_BASE -> strobes high asynchronously, FREE_MAP = 0, IDLE; a fresh START re-enumerates correctly.

Source files
------------

// File: rtl/zorro2_autoconfig_master.sv
// -----------------------------------------------------------------------------
// zorro2_autoconfig_master
//
// Host-side Zorro II AutoConfig initiator. After START it walks the config
// chain at $E80000. For each board it reads the type nibble and, for memory
// boards, the size nibble. It then places the board in the lowest free,
// naturally aligned 1MB slot of the $200000-$9FFFFF pool by writing register
// $24, or it shuts the board up by writing register $26.
//
// Ports
//   CLK        bus clock; all state changes on posedge
//   RESETn     asynchronous active-low reset
//   START      one-cycle pulse, accepted only in IDLE or DONE
//   RESERVED   1MB blocks $2..$9 already taken (bit0 = $2), latched on START
//   DTACKn     bus acknowledge, active-low
//   DBUS_IN    D[15:12] read from the bus
//   ASn/UDSn/LDSn  address/data strobes, active-low (LDSn is never asserted)
//   RWn        1 = read
//   ADDR       A[23:1]
//   DBUS_OUT   write nibble for D[15:12]
//   DBUS_OE    drive DBUS_OUT onto the bus
//   CFGOUTn    config chain enable to the first slot, active-low
//   BUSY       enumeration in progress
//   DONE       enumeration finished, held until the next START
//   FREE_MAP   allocated-block map (RESERVED OR all grants)
//   OFFERS     number of completed config writes, saturating at MAX_OFFERS
//   STATE_DBG  current enumeration state encoding
//
// Bus handshake: a cycle puts ADDR/RWn/DBUS_OE up for one clock (T0), then
// drops ASn/UDSn and holds them until DTACKn is sampled low. The strobes stay
// low one more clock, at the end of which read data is captured, and are then
// released. DBUS_OE follows one clock later, and one idle clock separates
// this cycle from the next. If DTACKn stays high for TIMEOUT clocks with the
// strobes low, the cycle ends the same way and is flagged as not acknowledged.
// -----------------------------------------------------------------------------
module zorro2_autoconfig_master #(
    parameter int TIMEOUT    = 16,
    parameter int MAX_OFFERS = 16
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        START,
    input  logic [7:0]  RESERVED,
    input  logic        DTACKn,
    input  logic [3:0]  DBUS_IN,
    output logic        ASn,
    output logic        UDSn,
    output logic        LDSn,
    output logic        RWn,
    output logic [22:0] ADDR,
    output logic [3:0]  DBUS_OUT,
    output logic        DBUS_OE,
    output logic        CFGOUTn,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  FREE_MAP,
    output logic [4:0]  OFFERS,
    output logic [2:0]  STATE_DBG
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_TYPE = 3'd1,
        ST_RD_SIZE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_WR_BASE = 3'd4,
        ST_WR_SHUT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Sub-phases of a single bus cycle.
    typedef enum logic [2:0] {
        PH_T0   = 3'd0,  // address and direction set up, strobes high
        PH_WAIT = 3'd1,  // strobes low, waiting for DTACKn
        PH_DATA = 3'd2,  // ack seen; strobes still low, data captured at end
        PH_REL  = 3'd3,  // strobes released, data bus still driven on writes
        PH_GAP  = 3'd4   // idle clock between cycles
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          noack_q, noack_d;
    logic [3:0]    rdata_q, rdata_d;
    logic [7:0]    free_map_q, free_map_d;
    logic [4:0]    offers_q, offers_d;
    logic [2:0]    offset_q, offset_d;
    logic [7:0]    mask_q, mask_d;

    logic          bus_state;
    logic          is_wr;
    logic          strobe;
    logic          cycle_end;
    logic [4:0]    offers_inc;

    // Placement search
    logic [3:0]    blk_n;
    logic          size_ok;
    logic [15:0]   run_mask;
    logic [15:0]   cand;
    logic          fit_found;
    logic [2:0]    fit_off;
    logic [7:0]    fit_mask;

    // -------------------------------------------------------------------------
    // Lowest naturally aligned run of blk_n free blocks. The scan goes from
    // the top offset down, so the last hit written is the lowest candidate.
    // blk_n is always a power of two, so alignment is a simple mask test.
    // -------------------------------------------------------------------------
    always_comb begin
        blk_n   = 4'd0;
        size_ok = 1'b1;
        case (rdata_q[2:0])
            3'b000:  blk_n = 4'd8;
            3'b111:  blk_n = 4'd4;
            3'b110:  blk_n = 4'd2;
            3'b101:  blk_n = 4'd1;
            default: size_ok = 1'b0;   // sub-1MB boards are not placed
        endcase
        run_mask  = (16'd1 << blk_n) - 16'd1;
        cand      = 16'd0;
        fit_found = 1'b0;
        fit_off   = 3'd0;
        fit_mask  = 8'd0;
        for (int off = 7; off >= 0; off--) begin
            cand = run_mask << off;
            if (size_ok && (cand[15:8] == 8'd0) &&
                ((cand[7:0] & free_map_q) == 8'd0) &&
                ((3'(off) & 3'(blk_n - 4'd1)) == 3'd0)) begin
                fit_found = 1'b1;
                fit_off   = 3'(off);
                fit_mask  = cand[7:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: bus-cycle sequencer plus enumeration FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        noack_d    = noack_q;
        rdata_d    = rdata_q;
        free_map_d = free_map_q;
        offers_d   = offers_q;
        offset_d   = offset_q;
        mask_d     = mask_q;
        cycle_end  = 1'b0;

        bus_state  = (state_q == ST_RD_TYPE) || (state_q == ST_RD_SIZE) ||
                     (state_q == ST_WR_BASE) || (state_q == ST_WR_SHUT);
        offers_inc = (offers_q == 5'(MAX_OFFERS)) ? offers_q : offers_q + 5'd1;

        if (bus_state) begin
            case (phase_q)
                PH_T0: begin
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                    noack_d = 1'b0;
                end
                PH_WAIT: begin
                    if (!DTACKn) begin
                        phase_d = PH_DATA;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        phase_d = PH_REL;
                        noack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PH_DATA: begin
                    phase_d = PH_REL;
                    rdata_d = DBUS_IN;
                end
                PH_REL: phase_d = PH_GAP;
                PH_GAP: begin
                    phase_d   = PH_T0;
                    cycle_end = 1'b1;
                end
                default: phase_d = PH_T0;
            endcase
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    free_map_d = RESERVED;
                    offers_d   = 5'd0;
                    phase_d    = PH_T0;
                    state_d    = ST_RD_TYPE;
                end
            end
            ST_RD_TYPE: begin
                if (cycle_end) begin
                    if (noack_q) begin
                        state_d = ST_DONE;
                    end else if ((rdata_q[3:2] != 2'b11) || !rdata_q[1]) begin
                        state_d = ST_WR_SHUT;  // not Zorro II, or not memory
                    end else begin
                        state_d = ST_RD_SIZE;
                    end
                end
            end
            ST_RD_SIZE: begin
                if (cycle_end) begin
                    state_d = noack_q ? ST_DONE : ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                offset_d = fit_off;
                mask_d   = fit_mask;
                state_d  = fit_found ? ST_WR_BASE : ST_WR_SHUT;
            end
            ST_WR_BASE, ST_WR_SHUT: begin
                if (cycle_end) begin
                    if (noack_q) begin
                        // An unacknowledged write grants nothing.
                        state_d = ST_DONE;
                    end else begin
                        if (state_q == ST_WR_BASE) begin
                            free_map_d = free_map_q | mask_q;
                        end
                        offers_d = offers_inc;
                        state_d  = (offers_inc == 5'(MAX_OFFERS)) ? ST_DONE
                                                                  : ST_RD_TYPE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_T0;
            cnt_q      <= '0;
            noack_q    <= 1'b0;
            rdata_q    <= 4'd0;
            free_map_q <= 8'd0;
            offers_q   <= 5'd0;
            offset_q   <= 3'd0;
            mask_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            noack_q    <= noack_d;
            rdata_q    <= rdata_d;
            free_map_q <= free_map_d;
            offers_q   <= offers_d;
            offset_q   <= offset_d;
            mask_q     <= mask_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs are decoded straight from the registers so that an asynchronous
    // reset releases the strobes immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        is_wr  = (state_q == ST_WR_BASE) || (state_q == ST_WR_SHUT);
        strobe = bus_state && ((phase_q == PH_WAIT) || (phase_q == PH_DATA));

        ASn      = ~strobe;
        UDSn     = ~strobe;
        LDSn     = 1'b1;
        RWn      = ~(is_wr && (phase_q != PH_GAP));
        DBUS_OE  = is_wr && (phase_q != PH_GAP);
        DBUS_OUT = (state_q == ST_WR_BASE) ? ({1'b0, offset_q} + 4'd2) : 4'd0;

        case (state_q)
            ST_RD_TYPE: ADDR = {8'hE8, 7'd0, 8'h00};
            ST_RD_SIZE: ADDR = {8'hE8, 7'd0, 8'h01};
            ST_WR_BASE: ADDR = {8'hE8, 7'd0, 8'h24};
            ST_WR_SHUT: ADDR = {8'hE8, 7'd0, 8'h26};
            default:    ADDR = 23'd0;
        endcase

        BUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        DONE      = (state_q == ST_DONE);
        CFGOUTn   = ~BUSY;
        FREE_MAP  = free_map_q;
        OFFERS    = offers_q;
        STATE_DBG = state_q;
    end

endmodule

// File: tb/tb_zorro2_autoconfig_master.sv
// -----------------------------------------------------------------------------
// Directed bench for zorro2_autoconfig_master. A small board model answers
// config cycles from a scripted list of offers, and the writes it accepts are
// checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_zorro2_autoconfig_master;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  reserved = 8'd0;
    logic        dtack_n;
    logic [3:0]  dbus_in;
    logic        asn, udsn, ldsn, rwn;
    logic [22:0] addr;
    logic [3:0]  dbus_out;
    logic        dbus_oe, cfgoutn, busy, done;
    logic [7:0]  free_map;
    logic [4:0]  offers;
    logic [2:0]  state_dbg;

    zorro2_autoconfig_master #(.TIMEOUT(16), .MAX_OFFERS(16)) dut (
        .CLK(clk), .RESETn(rst_n), .START(start), .RESERVED(reserved),
        .DTACKn(dtack_n), .DBUS_IN(dbus_in),
        .ASn(asn), .UDSn(udsn), .LDSn(ldsn), .RWn(rwn), .ADDR(addr),
        .DBUS_OUT(dbus_out), .DBUS_OE(dbus_oe), .CFGOUTn(cfgoutn),
        .BUSY(busy), .DONE(done), .FREE_MAP(free_map), .OFFERS(offers),
        .STATE_DBG(state_dbg)
    );

    // ---------------- board model ----------------
    logic       present = 1'b0;
    logic       hold_wr = 1'b0;      // never acknowledge writes
    logic       repeat_last = 1'b0;  // keep re-offering the last entry forever
    logic [3:0] ofr_type [8];
    logic [2:0] ofr_size [8];
    int         n_ofr = 0;
    int         ofr_idx = 0;
    int         size_reads = 0;
    logic       acked = 1'b0;

    assign dtack_n = !(!asn && present && !(hold_wr && !rwn));
    assign dbus_in = (addr[7:0] == 8'h00) ? ofr_type[ofr_idx] :
                     (addr[7:0] == 8'h01) ? {1'b0, ofr_size[ofr_idx]} : 4'h0;

    always @(posedge clk) if (!asn && !dtack_n) acked = 1'b1;

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];   // {register, data nibble} of expected writes
    logic [11:0] got_q[$];

    always @(posedge asn) begin
        if (rst_n && acked) begin
            if (!rwn) begin
                got_q.push_back({addr[7:0], dbus_out});
                if (addr[7:0] == 8'h24) begin
                    present = 1'b0;
                end else if (addr[7:0] == 8'h26) begin
                    if (ofr_idx < n_ofr - 1) ofr_idx++;
                    else if (!repeat_last) present = 1'b0;
                end
            end else if (addr[7:0] == 8'h01) begin
                size_reads++;
            end
        end
        acked = 1'b0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic board_load(input int n, input logic [3:0] t0, input logic [2:0] s0,
                              input logic [3:0] t1, input logic [2:0] s1,
                              input logic [3:0] t2, input logic [2:0] s2);
        for (int i = 0; i < 8; i++) begin
            ofr_type[i] = 4'h0;
            ofr_size[i] = 3'd0;
        end
        ofr_type[0] = t0; ofr_size[0] = s0;
        ofr_type[1] = t1; ofr_size[1] = s1;
        ofr_type[2] = t2; ofr_size[2] = s2;
        n_ofr       = n;
        ofr_idx     = 0;
        size_reads  = 0;
        present     = (n > 0);
        hold_wr     = 1'b0;
        repeat_last = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic pulse_start(input logic [7:0] res);
        @(negedge clk);
        reserved = res;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 1000 && !done; i++) @(negedge clk);
        chk(tag, done, 1'b1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_wr"}, got_q[i], exp_q[i]);
    endtask

    int asn_low;

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        #12;
        chk("rst_asn", asn, 1'b1);
        chk("rst_udsn", udsn, 1'b1);
        chk("rst_ldsn", ldsn, 1'b1);
        chk("rst_rwn", rwn, 1'b1);
        chk("rst_addr", addr, 23'd0);
        chk("rst_oe", dbus_oe, 1'b0);
        chk("rst_dout", dbus_out, 4'd0);
        chk("rst_cfgout", cfgoutn, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_map", free_map, 8'h00);
        chk("rst_offers", offers, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: one 8M board, nothing reserved -> base 2, full map
        board_load(1, 4'hE, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        exp_q.push_back({8'h24, 4'h2});
        pulse_start(8'h00);
        chk("t1_busy", busy, 1'b1);
        chk("t1_cfgout", cfgoutn, 1'b0);
        chk("t1_addr", addr, 23'h740000);
        chk("t1_asn_t0", asn, 1'b1);
        @(negedge clk);
        chk("t1_asn_t1", asn, 1'b0);
        wait_done("t1_done");
        chk("t1_map", free_map, 8'hFF);
        chk("t1_offers", offers, 5'd1);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_cfgout_end", cfgoutn, 1'b1);
        chk("t1_size_reads", size_reads, 1);
        check_writes("t1");

        // 2: $2 reserved; 8M shut up, then 4M placed at $6
        board_load(3, 4'hE, 3'd0, 4'hE, 3'd7, 4'hE, 3'd6);
        exp_q.push_back({8'h26, 4'h0});
        exp_q.push_back({8'h24, 4'h6});
        pulse_start(8'h01);
        wait_done("t2_done");
        chk("t2_map", free_map, 8'hF1);
        chk("t2_offers", offers, 5'd2);
        check_writes("t2");

        // 3: $2 reserved, 2M board -> base 4
        board_load(1, 4'hE, 3'd6, 4'h0, 3'd0, 4'h0, 3'd0);
        exp_q.push_back({8'h24, 4'h4});
        pulse_start(8'h01);
        wait_done("t3_done");
        chk("t3_map", free_map, 8'h0D);
        chk("t3_offers", offers, 5'd1);
        check_writes("t3");

        // 4: pool full, 1M board -> shut up
        board_load(1, 4'hE, 3'd5, 4'h0, 3'd0, 4'h0, 3'd0);
        exp_q.push_back({8'h26, 4'h0});
        pulse_start(8'hFF);
        wait_done("t4_done");
        chk("t4_map", free_map, 8'hFF);
        chk("t4_offers", offers, 5'd1);
        check_writes("t4");

        // 5: non-memory board -> shut up without a size read
        board_load(1, 4'hC, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        exp_q.push_back({8'h26, 4'h0});
        pulse_start(8'h00);
        wait_done("t5_done");
        chk("t5_offers", offers, 5'd1);
        chk("t5_map", free_map, 8'h00);
        chk("t5_size_reads", size_reads, 0);
        check_writes("t5");

        // 6: empty chain -> strobes low exactly 16 clocks, then done
        board_load(0, 4'h0, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        pulse_start(8'hA5);
        asn_low = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (!asn) asn_low++;
            @(negedge clk);
        end
        chk("t6_done", done, 1'b1);
        chk("t6_asn_low", asn_low, 16);
        chk("t6_offers", offers, 5'd0);
        chk("t6_map", free_map, 8'hA5);
        check_writes("t6");

        // 7: endless non-memory offers -> stops at 16 config cycles
        board_load(1, 4'hC, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        repeat_last = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back({8'h26, 4'h0});
        pulse_start(8'h00);
        wait_done("t7_done");
        chk("t7_offers", offers, 5'd16);
        check_writes("t7");

        // 8: reset while the base write is on the bus
        board_load(1, 4'hE, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        hold_wr = 1'b1;
        pulse_start(8'h00);
        for (int i = 0; i < 300 && !(!asn && addr[7:0] == 8'h24); i++) @(negedge clk);
        chk("t8_in_wrbase", {asn, addr[7:0]}, {1'b0, 8'h24});
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_asn", asn, 1'b1);
        chk("t8_udsn", udsn, 1'b1);
        chk("t8_oe", dbus_oe, 1'b0);
        chk("t8_map", free_map, 8'h00);
        chk("t8_offers", offers, 5'd0);
        chk("t8_state", state_dbg, 3'd0);
        chk("t8_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        board_load(1, 4'hE, 3'd0, 4'h0, 3'd0, 4'h0, 3'd0);
        exp_q.push_back({8'h24, 4'h2});
        pulse_start(8'h00);
        wait_done("t8_redo_done");
        chk("t8_redo_map", free_map, 8'hFF);
        chk("t8_redo_offers", offers, 5'd1);
        check_writes("t8_redo");

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
